adm_decoder_mc: RTL and testbench

- Multi-channel adaptive delta-modulation (DSM bitstream) to binary decoder. Each channel keeps a bit history, adapts its step size by powers of two and integrates the bitstream into a saturating OUT_W-bit accumulator.
- All channels share one bit strobe and one decimation counter. Every DECIM accepted bits, the block emits one snapshot word per channel.
- Sits between the per-electrode comparator bit inputs and the sample packer/FIFO.

---
 rtl/adm_pkg.sv | 32 +++
 rtl/adm_decoder_mc_if.sv | 25 ++
 rtl/adm_channel.sv | 82 ++++++++
 rtl/adm_decoder_mc.sv | 79 +++++++
 tb/tb_adm_decoder_mc.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/adm_pkg.sv
// Shared constants and helpers for the adaptive delta-modulation decoder.
package adm_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = 32'(i) + 32'd1;
    end
    return r;
  endfunction

  // Accumulator centre value, 2^(w-1).
  function automatic logic [31:0] midscale(input int unsigned w);
    return 32'd1 << (w - 32'd1);
  endfunction

  // Alternating history with bit0 = 0, so a fresh channel starts with no run.
  function automatic logic [31:0] hist_init(input int unsigned n);
    logic [31:0] h;
    h = '0;
    for (int i = 0; i < 32; i++) begin
      if ((32'(i) < n) && ((i % 2) == 1)) h[i] = 1'b1;
    end
    return h;
  endfunction

  function automatic int unsigned ch_lsb(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/adm_decoder_mc_if.sv
// Control, bitstream and snapshot signals of the multi-channel decoder.
interface adm_decoder_mc_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned OUT_W  = 12,
  parameter int unsigned SH_W   = 3
);
  logic                      enable;
  logic                      clear;
  logic                      bit_valid;
  logic [NUM_CH-1:0]         in_bits;
  logic                      out_valid;
  logic [NUM_CH*OUT_W-1:0]   out_data;
  logic [NUM_CH*SH_W-1:0]    out_shift;
  logic [NUM_CH-1:0]         sat_flag;

  modport master (
    output enable, clear, bit_valid, in_bits,
    input  out_valid, out_data, out_shift, sat_flag
  );

  modport slave (
    input  enable, clear, bit_valid, in_bits,
    output out_valid, out_data, out_shift, sat_flag
  );
endinterface

// File: rtl/adm_channel.sv
// One decoder channel: bit history, power-of-two step adaptation and a
// saturating integrator. acc_next_c is the post-beat value for snapshotting.
module adm_channel
  import adm_pkg::*;
#(
  parameter int unsigned OUT_W     = 12,
  parameter int unsigned RUN_LEN   = 5,
  parameter int unsigned MAX_SHIFT = 7,
  parameter int unsigned SH_W      = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             beat,
  input  logic             bit_in,
  output logic [OUT_W-1:0] acc_next_c,
  output logic [SH_W-1:0]  shift,
  output logic             sat
);

  localparam int unsigned       ACC_W    = OUT_W + 1;
  localparam logic [RUN_LEN-1:0] HIST_RST = RUN_LEN'(hist_init(RUN_LEN));
  localparam logic [OUT_W-1:0]  ACC_RST  = OUT_W'(midscale(OUT_W));
  localparam logic [OUT_W-1:0]  ACC_TOP  = '1;
  localparam logic [SH_W-1:0]   SH_MAX   = SH_W'(MAX_SHIFT);

  logic [RUN_LEN-1:0] hist;
  logic [RUN_LEN-1:0] hist_c;
  logic [OUT_W-1:0]   acc;
  logic [SH_W-1:0]    shift_c;
  logic [ACC_W-1:0]   step_c;
  logic [ACC_W-1:0]   sum_c;
  logic [ACC_W-1:0]   diff_c;
  logic               clamp_c;

  // Step adaptation (run rule wins over alternation), then one extra bit of
  // headroom to catch overflow/underflow before clamping.
  always_comb begin
    hist_c     = {hist[RUN_LEN-2:0], bit_in};
    shift_c    = shift;
    clamp_c    = 1'b0;
    acc_next_c = acc;
    if ((hist_c == '0) || (hist_c == '1)) begin
      if (shift != SH_MAX) shift_c = shift + SH_W'(1);
    end else if ((hist_c[0] != hist_c[1]) && (hist_c[1] != hist_c[2])) begin
      if (shift != '0) shift_c = shift - SH_W'(1);
    end
    step_c = ACC_W'(1) << shift_c;
    sum_c  = {1'b0, acc} + step_c;
    diff_c = {1'b0, acc} - step_c;
    if (bit_in) begin
      if (sum_c[OUT_W]) begin
        acc_next_c = ACC_TOP;
        clamp_c    = 1'b1;
      end else begin
        acc_next_c = sum_c[OUT_W-1:0];
      end
    end else begin
      if (diff_c[OUT_W]) begin
        acc_next_c = '0;
        clamp_c    = 1'b1;
      end else begin
        acc_next_c = diff_c[OUT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      hist  <= HIST_RST;
      shift <= '0;
      acc   <= ACC_RST;
      sat   <= 1'b0;
    end else if (beat) begin
      hist  <= hist_c;
      shift <= shift_c;
      acc   <= acc_next_c;
      if (clamp_c) sat <= 1'b1;
    end
  end

endmodule

// File: rtl/adm_decoder_mc.sv
// Multi-channel adaptive delta-modulation decoder with a shared decimation
// counter and a per-channel output snapshot.
module adm_decoder_mc
  import adm_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned OUT_W      = 12,
  parameter int unsigned RUN_LEN    = 5,
  parameter int unsigned MAX_SHIFT  = 7,
  parameter int unsigned DECIM      = 16,
  parameter bit          OUT_SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  adm_decoder_mc_if.slave  bus
);

  localparam int unsigned      SH_W     = clog2(MAX_SHIFT + 1);
  localparam int unsigned      CNT_W    = clog2(DECIM + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);
  localparam logic [OUT_W-1:0] MSB_FLIP = OUT_SIGNED ? OUT_W'(midscale(OUT_W)) : '0;
  localparam logic [OUT_W-1:0] OUT_RST  = OUT_W'(midscale(OUT_W)) ^ MSB_FLIP;

  logic                    beat_c;
  logic [CNT_W-1:0]        cnt;
  logic [NUM_CH*OUT_W-1:0] acc_next_c;
  logic [NUM_CH*OUT_W-1:0] snap_c;
  logic [NUM_CH*OUT_W-1:0] out_data;
  logic                    out_valid;
  logic [NUM_CH*SH_W-1:0]  shift_all;
  logic [NUM_CH-1:0]       sat_all;

  assign beat_c = bus.enable & bus.bit_valid & ~bus.clear;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    adm_channel #(
      .OUT_W     (OUT_W),
      .RUN_LEN   (RUN_LEN),
      .MAX_SHIFT (MAX_SHIFT),
      .SH_W      (SH_W)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .clear      (bus.clear),
      .beat       (beat_c),
      .bit_in     (bus.in_bits[k]),
      .acc_next_c (acc_next_c[ch_lsb(k, OUT_W) +: OUT_W]),
      .shift      (shift_all[ch_lsb(k, SH_W) +: SH_W]),
      .sat        (sat_all[k])
    );
    assign snap_c[ch_lsb(k, OUT_W) +: OUT_W] = acc_next_c[ch_lsb(k, OUT_W) +: OUT_W] ^ MSB_FLIP;
  end

  // Decimation counter; the last beat of each frame captures post-update values.
  always_ff @(posedge clk) begin
    if (reset || bus.clear) begin
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= {NUM_CH{OUT_RST}};
    end else begin
      out_valid <= 1'b0;
      if (beat_c) begin
        if (cnt == CNT_LAST) begin
          cnt       <= '0;
          out_valid <= 1'b1;
          out_data  <= snap_c;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.out_shift = shift_all;
  assign bus.sat_flag  = sat_all;

endmodule

// File: tb/tb_adm_decoder_mc.sv
// Directed bench for adm_decoder_mc: table-driven ramp plus saturation,
// clear, enable-hold and signed/short-decimation sequences.
module tb_adm_decoder_mc;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  adm_decoder_mc_if #(.NUM_CH(4), .OUT_W(12), .SH_W(3)) bus ();
  adm_decoder_mc_if #(.NUM_CH(4), .OUT_W(12), .SH_W(3)) sbus ();

  adm_decoder_mc #(
    .NUM_CH(4), .OUT_W(12), .RUN_LEN(5), .MAX_SHIFT(7), .DECIM(16), .OUT_SIGNED(1'b0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  adm_decoder_mc #(
    .NUM_CH(4), .OUT_W(12), .RUN_LEN(5), .MAX_SHIFT(7), .DECIM(4), .OUT_SIGNED(1'b1)
  ) dut_s (
    .clk   (clk),
    .reset (reset),
    .bus   (sbus)
  );

  typedef struct {
    logic [3:0] bits;
    logic [2:0] exp_sh0;
    logic       exp_valid;
  } vec_t;

  vec_t tbl[16];
  int   sh_exp[16];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [11:0] och(input int k);
    return bus.out_data[k*12 +: 12];
  endfunction

  task automatic beat(input logic en, input logic clr, input logic bv, input logic [3:0] bits);
    bus.enable    = en;
    bus.clear     = clr;
    bus.bit_valid = bv;
    bus.in_bits   = bits;
    @(posedge clk);
    #1;
  endtask

  task automatic sbeat(input logic [3:0] bits);
    sbus.enable    = 1'b1;
    sbus.clear     = 1'b0;
    sbus.bit_valid = 1'b1;
    sbus.in_bits   = bits;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.enable = 1'b0; bus.clear = 1'b0; bus.bit_valid = 1'b0; bus.in_bits = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic alt;
    sbus.enable = 1'b0; sbus.clear = 1'b0; sbus.bit_valid = 1'b0; sbus.in_bits = '0;
    sh_exp = '{0, 0, 0, 0, 1, 2, 3, 4, 5, 6, 7, 7, 7, 7, 7, 7};
    for (int i = 0; i < 16; i++) begin
      alt = ((i % 2) == 0);
      tbl[i].bits      = {alt, alt, alt, 1'b1};
      tbl[i].exp_sh0   = 3'(sh_exp[i]);
      tbl[i].exp_valid = (i == 15);
    end

    // Reset defaults on both instances
    do_reset();
    check("rst_data", 64'(bus.out_data), 64'({4{12'd2048}}));
    check("rst_shift", 64'(bus.out_shift), 64'd0);
    check("rst_sat", 64'(bus.sat_flag), 64'd0);
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_sdata", 64'(sbus.out_data), 64'd0);

    // ch0 ramp, ch1..3 alternating: shift trajectory and strobe timing
    for (int i = 0; i < 16; i++) begin
      beat(1'b1, 1'b0, 1'b1, tbl[i].bits);
      check("ramp_shift0", 64'(bus.out_shift[2:0]), 64'(tbl[i].exp_sh0));
      check("ramp_shift1", 64'(bus.out_shift[5:3]), 64'd0);
      check("ramp_valid", 64'(bus.out_valid), 64'(tbl[i].exp_valid));
    end
    check("ramp_ch0", 64'(och(0)), 64'd2946);
    check("ramp_ch1", 64'(och(1)), 64'd2048);
    check("ramp_ch3", 64'(och(3)), 64'd2048);
    check("ramp_sat", 64'(bus.sat_flag), 64'd0);
    beat(1'b1, 1'b0, 1'b0, 4'b0000);
    check("idle_valid", 64'(bus.out_valid), 64'd0);
    check("idle_hold", 64'(och(0)), 64'd2946);

    // ch2 ones, others zeros for 40 beats: both rails clamp
    do_reset();
    for (int i = 0; i < 40; i++) begin
      beat(1'b1, 1'b0, 1'b1, 4'b0100);
      if (i == 15) begin
        check("sat16_valid", 64'(bus.out_valid), 64'd1);
        check("sat16_ch2", 64'(och(2)), 64'd2946);
        check("sat16_ch0", 64'(och(0)), 64'd1023);
      end
      if (i == 19) check("sat20_flag", 64'(bus.sat_flag), 64'd0);
      if (i == 31) begin
        check("sat32_valid", 64'(bus.out_valid), 64'd1);
        check("sat32_ch2", 64'(och(2)), 64'd4095);
        check("sat32_ch0", 64'(och(0)), 64'd0);
      end
    end
    check("sat40_flag", 64'(bus.sat_flag), 64'hf);
    check("sat40_valid", 64'(bus.out_valid), 64'd0);
    for (int i = 0; i < 8; i++) beat(1'b1, 1'b0, 1'b1, 4'b0000);
    check("down_valid", 64'(bus.out_valid), 64'd1);
    check("down_ch2", 64'(och(2)), 64'd3071);
    check("down_shift2", 64'(bus.out_shift[8:6]), 64'd7);
    check("down_sat", 64'(bus.sat_flag), 64'hf);

    // clear with bit_valid re-centres everything
    beat(1'b1, 1'b1, 1'b1, 4'b1111);
    check("clr_data", 64'(bus.out_data), 64'({4{12'd2048}}));
    check("clr_sat", 64'(bus.sat_flag), 64'd0);
    check("clr_shift", 64'(bus.out_shift), 64'd0);
    check("clr_valid", 64'(bus.out_valid), 64'd0);

    // six beats, then clear on the 7th: that bit is dropped
    for (int i = 0; i < 6; i++) beat(1'b1, 1'b0, 1'b1, 4'b0001);
    check("pre_clr_shift0", 64'(bus.out_shift[2:0]), 64'd2);
    beat(1'b1, 1'b1, 1'b1, 4'b0001);
    check("clr7_shift0", 64'(bus.out_shift[2:0]), 64'd0);
    for (int i = 0; i < 10; i++) beat(1'b1, 1'b0, 1'b1, 4'b0001);
    check("b10_shift0", 64'(bus.out_shift[2:0]), 64'd6);
    // enable low with bit_valid high holds all state
    for (int i = 0; i < 5; i++) begin
      beat(1'b0, 1'b0, 1'b1, 4'b1111);
      check("en_lo_valid", 64'(bus.out_valid), 64'd0);
    end
    check("en_lo_shift0", 64'(bus.out_shift[2:0]), 64'd6);
    for (int i = 10; i < 16; i++) begin
      beat(1'b1, 1'b0, 1'b1, 4'b0001);
      check("post_clr_valid", 64'(bus.out_valid), 64'(i == 15));
    end
    check("post_clr_ch0", 64'(och(0)), 64'd2946);
    check("post_clr_ch1", 64'(och(1)), 64'd1023);

    // signed output, DECIM=4
    bus.enable = 1'b0; bus.bit_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sbeat(4'b1111);
      check("s_valid", 64'(sbus.out_valid), 64'(i == 3));
    end
    check("s_data", 64'(sbus.out_data), 64'({4{12'h004}}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
